// File: rtl/sysbus_mem_responder_if.sv
// Cache-side system bus: one initiator (master) and the memory responder (slave).
interface sysbus_mem_responder_if #(
   parameter int DATA_W = 64,
   parameter int TAG_W  = 13
);
   logic              bus_reqcyc;
   logic [DATA_W-1:0] bus_req;
   logic [TAG_W-1:0]  bus_reqtag;
   logic              bus_respack;
   logic              bus_reqack;
   logic              bus_respcyc;
   logic [DATA_W-1:0] bus_resp;
   logic [TAG_W-1:0]  bus_resptag;

   modport master (
      output bus_reqcyc, bus_req, bus_reqtag, bus_respack,
      input  bus_reqack, bus_respcyc, bus_resp, bus_resptag
   );

   modport slave (
      input  bus_reqcyc, bus_req, bus_reqtag, bus_respack,
      output bus_reqack, bus_respcyc, bus_resp, bus_resptag
   );
endinterface

// File: rtl/sysbus_mem_responder.sv
// Line-granular memory responder: 8-beat reads, 8-beat writes, snoop-invalidate after each write.
// state     | meaning
// IDLE      | wait for bus_reqcyc, latch line address and tag
// ACK       | one-cycle bus_reqack, branch on tag[8]
// RD_WAIT   | read latency down-count
// RD_BURST  | eight read beats
// WR_DATA   | collect eight write beats (reqcyc=0 stalls)
// WR_COMMIT | store assembled line
// INV       | snoop-invalidate beat with the line address
module sysbus_mem_responder #(
   parameter int                       BUS_DATA_WIDTH = 64,
   parameter int                       BUS_TAG_WIDTH  = 13,
   parameter int                       MEM_LINES      = 1024,
   parameter int                       READ_LATENCY   = 4,
   parameter logic [BUS_TAG_WIDTH-1:0] INV_TAG        = 13'h0800
) (
   input logic                   clk,
   input logic                   reset,
   sysbus_mem_responder_if.slave bus
);
   localparam int IDX_W  = $clog2(MEM_LINES);
   localparam int LINE_W = 8 * BUS_DATA_WIDTH;
   localparam int ADDR_W = BUS_DATA_WIDTH - 6;
   localparam int CNT_W  = $clog2(READ_LATENCY + 1);

   typedef enum logic [2:0] {
      ST_IDLE, ST_ACK, ST_RD_WAIT, ST_RD_BURST, ST_WR_DATA, ST_WR_COMMIT, ST_INV
   } state_t;

   state_t                   state, state_nx;
   logic [ADDR_W-1:0]        line_q;
   logic [BUS_TAG_WIDTH-1:0] tag_q;
   logic [CNT_W-1:0]         wait_cnt;
   logic [3:0]               beat;
   logic [LINE_W-1:0]        wbuf;
   logic [LINE_W-1:0]        mem [MEM_LINES];
   logic [IDX_W-1:0]         idx;
   logic                     unused_respack;

   assign idx            = line_q[IDX_W-1:0];
   assign unused_respack = bus.bus_respack;

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE:      if (bus.bus_reqcyc) state_nx = ST_ACK;
         ST_ACK:       state_nx = tag_q[8] ? ST_RD_WAIT : ST_WR_DATA;
         ST_RD_WAIT:   if (wait_cnt == '0) state_nx = ST_RD_BURST;
         ST_RD_BURST:  if (beat == 4'd8) state_nx = ST_IDLE;
         ST_WR_DATA:   if (bus.bus_reqcyc && beat == 4'd7) state_nx = ST_WR_COMMIT;
         ST_WR_COMMIT: state_nx = ST_INV;
         ST_INV:       state_nx = ST_IDLE;
         default:      state_nx = ST_IDLE;
      endcase
   end

   // Outputs are registered from the next state so they line up with the state they belong to.
   always_ff @(posedge clk) begin
      if (reset) begin
         state           <= ST_IDLE;
         line_q          <= '0;
         tag_q           <= '0;
         wait_cnt        <= '0;
         beat            <= '0;
         bus.bus_reqack  <= 1'b0;
         bus.bus_respcyc <= 1'b0;
         bus.bus_resp    <= '0;
         bus.bus_resptag <= '0;
      end else begin
         state           <= state_nx;
         bus.bus_reqack  <= (state_nx == ST_ACK);
         bus.bus_respcyc <= (state_nx == ST_RD_BURST) || (state_nx == ST_INV);
         case (state)
            ST_IDLE: begin
               beat <= '0;
               if (bus.bus_reqcyc) begin
                  line_q <= bus.bus_req[BUS_DATA_WIDTH-1:6];
                  tag_q  <= bus.bus_reqtag;
               end
            end
            ST_ACK: begin
               beat     <= '0;
               wait_cnt <= CNT_W'(READ_LATENCY - 1);
            end
            ST_RD_WAIT: if (wait_cnt != '0) wait_cnt <= wait_cnt - 1'b1;
            ST_WR_DATA: if (bus.bus_reqcyc) beat <= beat + 4'd1;
            default: ;
         endcase
         if (state_nx == ST_RD_BURST) begin
            bus.bus_resp    <= mem[idx][beat[2:0]*BUS_DATA_WIDTH +: BUS_DATA_WIDTH];
            bus.bus_resptag <= tag_q;
            beat            <= beat + 4'd1;
         end
         if (state_nx == ST_INV) begin
            bus.bus_resp    <= {line_q, 6'b0};
            bus.bus_resptag <= INV_TAG;
         end
      end
   end

   // Line store and write assembly buffer carry no reset; a partial write never reaches commit.
   always_ff @(posedge clk) begin
      if (state == ST_WR_DATA && bus.bus_reqcyc)
         wbuf[beat[2:0]*BUS_DATA_WIDTH +: BUS_DATA_WIDTH] <= bus.bus_req;
      if (!reset && state == ST_WR_COMMIT)
         mem[idx] <= wbuf;
   end
endmodule

// File: doc/sysbus_mem_responder.md
# sysbus_mem_responder

Memory-side responder for the 64-bit system bus used by the core's caches. It accepts line-granular read and write requests from one initiator and serves them from an internal line store. Reads return a 512-bit line as eight beats; writes accept eight beats. After every completed write it broadcasts a snoop-invalidate beat so that other caches drop stale copies of the line. It sits at the memory end of the bus arbiter, opposite the icache/dcache initiators.

## Interface
- BUS_DATA_WIDTH, 64, beat width; fixed at 64.
- BUS_TAG_WIDTH, 13, request/response tag width.
- MEM_LINES, 1024, number of 64-byte lines in the store; power of two.
- READ_LATENCY, 4, idle cycles between the reqack pulse and the first read beat; minimum 1.
- INV_TAG, 13'h0800, response tag used for snoop-invalidate beats.

Ports:
- clk  in  1  sole clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high.
- bus_reqcyc  in  1  request valid; the initiator also holds it high during write data beats.
- bus_req  in  64  request address (first cycle), then write data beats.
- bus_reqtag  in  13  request tag; bit 8 = 1 for read, 0 for write; other bits echoed only.
- bus_respack  in  1  initiator response acknowledge; monitored, not used for flow control.
- bus_reqack  out  1  one-cycle acceptance pulse for the address phase.
- bus_respcyc  out  1  response beat valid.
- bus_resp  out  64  read data beat, or line address for an invalidate beat.
- bus_resptag  out  13  latched request tag for read beats; INV_TAG for invalidate beats.

## Operation
- Line index = addr[6+log2(MEM_LINES)-1:6]. Higher address bits are ignored, so out-of-range addresses wrap modulo MEM_LINES. addr[5:0] is ignored; every transfer is a whole line.
- The store is not cleared by reset. Simulation contents start at 0.
- FSM states:
  - IDLE: if bus_reqcyc=1, latch {line address, tag}, go to ACK.
  - ACK: bus_reqack=1 for this cycle only. Next state is RD_WAIT if tag[8]=1, otherwise WR_DATA.
  - RD_WAIT: count READ_LATENCY cycles, then go to RD_BURST.
  - RD_BURST: bus_respcyc=1 for exactly 8 consecutive cycles. Beat k (k=0..7) carries line[64k+63:64k], i.e. byte offsets 0,8,…,56 in order. bus_resptag holds the latched tag throughout. Then go to IDLE.
  - WR_DATA: on each cycle with bus_reqcyc=1, capture bus_req into beat slot k and increment k. Cycles with reqcyc=0 are stalls. After the 8th beat, go to WR_COMMIT.
  - WR_COMMIT: write the assembled 512 bits to the store in one cycle, then go to INV.
  - INV: one cycle with bus_respcyc=1, bus_resp={line address[63:6],6'b0}, bus_resptag=INV_TAG. No ack is expected. Then go to IDLE.
- Requests arriving outside IDLE are ignored: no reqack, no state change. The initiator must hold or re-present them.
- After any return to IDLE, bus_reqcyc is sampled again starting on the next cycle. A reqcyc left high from a previous write is a new request.
- Read-after-write to the same line returns the newly written data, because the commit precedes any later read access.

## Timing
- Reset values: bus_reqack=0, bus_respcyc=0, bus_resp=0, bus_resptag=0, FSM=IDLE, beat counters=0. All outputs are registered.
- Reset asserted mid-transaction returns the FSM to IDLE on the same edge. bus_respcyc is 0 from the next cycle. A partial write is discarded: no store update, no invalidate.
- Read, request sampled in IDLE at cycle T:
  - reqack at T+1.
  - first beat at T+2+READ_LATENCY.
  - last beat at T+9+READ_LATENCY.
  - IDLE at T+10+READ_LATENCY.
- Write with no stalls, request at T:
  - reqack at T+1.
  - data beats sampled T+2..T+9.
  - commit at T+10.
  - invalidate beat at T+11.
  - IDLE at T+12.
- bus_resp holds its last value when bus_respcyc=0. Checkers must qualify data with bus_respcyc.

## Test plan
- Write line 0x1000 with beats 0x11..0x88, then read 0x1000 with tag 13'h0100. Expected: 8 beats 0x11..0x88 in order, resptag=13'h0100, reqack at T+1, first beat at T+6 (READ_LATENCY=4).
- Write completion at address 0x2040: expected exactly one beat with resptag=13'h0800 and bus_resp=0x2040 at T+11, and no reqack other than the one at T+1.
- Write with reqcyc dropped for 3 cycles after beat 3: expected 8 beats captured, commit delayed by 3 cycles, readback correct.
- Assert reset during read beat 4: expected bus_respcyc=0 on the next cycle; a new read issued afterwards completes normally.
- Address wrap with MEM_LINES=1024: write 0x10000 (index 0), then read 0x0. Expected: the written data is returned.
- Present reqcyc during RD_BURST: expected no reqack until the FSM is back in IDLE, then a normal ack at the following cycle.
